mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and select controller for an 8-input multiplexer datapath. Eight requesters compete for a single shared output channel; the block grants one requester at a time, drives the 3-bit mux select, and registers the selected requester's data onto the output for a bounded burst. It sits in front of the 8x1 mux stage and turns it from a static selector into a fair, time-shared resource.

---
 rtl/mux8_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and select controller for an 8:1 mux datapath.
// Grants one requester at a time for a bounded burst and registers its beats onto the output.
module mux8_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         gnt_r, gnt_s;
  logic [2:0]         sel_r, sel_s;
  logic [2:0]         ptr_r, ptr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               out_valid_r, out_valid_s;
  logic [WIDTH-1:0]   out_data_r, out_data_s;

  logic [2:0]         idx_s;
  logic [2:0]         win_s;
  logic               found_s;
  logic [WIDTH-1:0]   sel_data_s;

  // First requester at or after ptr in circular order
  always_comb begin
    win_s   = ptr_r;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int k = 0; k < 8; k++) begin
      idx_s = ptr_r + 3'(k);
      if (!found_s && req[idx_s]) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign sel_data_s = in_data[int'(sel_r)*WIDTH +: WIDTH];

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    sel_s       = sel_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    busy_s      = busy_r;
    out_valid_s = 1'b0;
    out_data_s  = out_data_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANT;
          gnt_s   = 8'(8'h01 << win_s);
          sel_s   = win_s;
          busy_s  = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          ptr_s   = win_s + 3'd1;
        end else begin
          gnt_s  = 8'h00;
          busy_s = 1'b0;
        end
      end
      GRANT: begin
        if (req[sel_r]) begin
          out_valid_s = 1'b1;
          out_data_s  = sel_data_s;
          cnt_s       = cnt_r + CNT_W'(1'b1);
          // Burst budget exhausted: hand the channel back for re-arbitration
          if (cnt_r + CNT_W'(1'b1) == CNT_W'(MAX_BURST)) begin
            state_s = IDLE;
            gnt_s   = 8'h00;
            busy_s  = 1'b0;
          end else begin
            state_s = GRANT;
          end
        end else begin
          state_s = IDLE;
          gnt_s   = 8'h00;
          busy_s  = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 8'h00;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= 8'h00;
      sel_r       <= 3'd0;
      ptr_r       <= 3'd0;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      sel_r       <= sel_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance,
// a cycle model queues expected outputs, plus directed checks on beat and grant sequences.
module tb_mux8_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst4, rst1;
  logic [7:0]  req4, req1;
  logic [63:0] in_data;
  logic [7:0]  gnt4, gnt1;
  logic [2:0]  sel4, sel1;
  logic        busy4, busy1, ov4, ov1;
  logic [7:0]  od4, od1;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .in_data(in_data),
    .gnt(gnt4), .sel(sel4), .busy(busy4), .out_valid(ov4), .out_data(od4)
  );

  mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .in_data(in_data),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .out_valid(ov1), .out_data(od1)
  );

  int n_pass  = 0;
  int n_total = 0;
  string phase = "init";

  // Reference model state, one slot per instance
  logic       m_grant [2];
  logic [7:0] m_gnt   [2];
  logic [2:0] m_sel   [2];
  logic [2:0] m_ptr   [2];
  int         m_cnt   [2];
  logic       m_ov    [2];
  logic [7:0] m_od    [2];
  int         mb      [2];

  logic [20:0] exp_q [$];
  logic [7:0]  obs_q [$];
  logic [7:0]  gq    [$];
  logic [7:0]  prev_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
  endtask

  task automatic model_reset(input int i);
    m_grant[i] = 1'b0; m_gnt[i] = 8'h00; m_sel[i] = 3'd0; m_ptr[i] = 3'd0;
    m_cnt[i] = 0; m_ov[i] = 1'b0; m_od[i] = 8'h00;
  endtask

  task automatic model_step(input int i, input logic r, input logic [7:0] rq);
    int  w;
    logic hit;
    if (r) begin
      model_reset(i);
    end else if (!m_grant[i]) begin
      m_ov[i] = 1'b0;
      hit = 1'b0;
      w = 0;
      for (int k = 0; k < 8; k++) begin
        if (!hit && rq[(int'(m_ptr[i]) + k) % 8]) begin
          w = (int'(m_ptr[i]) + k) % 8;
          hit = 1'b1;
        end
      end
      if (hit) begin
        m_grant[i] = 1'b1;
        m_gnt[i]   = 8'h00;
        m_gnt[i][w] = 1'b1;
        m_sel[i]   = 3'(w);
        m_cnt[i]   = 0;
        m_ptr[i]   = 3'((w + 1) % 8);
      end
    end else if (rq[m_sel[i]]) begin
      m_ov[i] = 1'b1;
      m_od[i] = in_data[int'(m_sel[i])*8 +: 8];
      m_cnt[i]++;
      if (m_cnt[i] == mb[i]) begin
        m_grant[i] = 1'b0;
        m_gnt[i]   = 8'h00;
      end
    end else begin
      m_ov[i]    = 1'b0;
      m_grant[i] = 1'b0;
      m_gnt[i]   = 8'h00;
    end
  endtask

  task automatic run_cycle(input int i, input logic r, input logic [7:0] rq);
    logic [20:0] e, g;
    @(negedge clk);
    if (i == 0) begin
      rst4 = r; req4 = rq; rst1 = 1'b1; req1 = 8'h00;
    end else begin
      rst1 = r; req1 = rq; rst4 = 1'b1; req4 = 8'h00;
    end
    model_step(i, r, rq);
    exp_q.push_back({m_gnt[i], m_sel[i], m_grant[i], m_ov[i], m_od[i]});
    @(posedge clk);
    #1;
    g = (i == 0) ? {gnt4, sel4, busy4, ov4, od4} : {gnt1, sel1, busy1, ov1, od1};
    e = exp_q.pop_front();
    check_eq("gnt",       32'(g[20:13]), 32'(e[20:13]));
    check_eq("sel",       32'(g[12:10]), 32'(e[12:10]));
    check_eq("busy",      32'(g[9]),     32'(e[9]));
    check_eq("out_valid", 32'(g[8]),     32'(e[8]));
    check_eq("out_data",  32'(g[7:0]),   32'(e[7:0]));
    if (g[8]) obs_q.push_back(g[7:0]);
    if (g[20:13] != 8'h00 && prev_gnt == 8'h00) gq.push_back(g[20:13]);
    prev_gnt = g[20:13];
  endtask

  task automatic clear_obs();
    obs_q.delete();
    gq.delete();
  endtask

  initial begin
    logic [7:0] one;
    one = 8'h01;
    mb[0] = 4; mb[1] = 1;
    model_reset(0); model_reset(1);
    prev_gnt = 8'h00;
    rst4 = 1'b1; rst1 = 1'b1; req4 = 8'h00; req1 = 8'h00;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(one << i);

    phase = "reset";
    run_cycle(0, 1'b1, 8'hFF);
    run_cycle(0, 1'b1, 8'hFF);
    run_cycle(0, 1'b0, 8'h00);
    check_eq("gnt_after", 32'(gnt4), 32'h0);
    check_eq("od_after", 32'(od4), 32'h0);

    phase = "single";
    in_data[24 +: 8] = 8'h5A;
    clear_obs();
    for (int c = 0; c < 15; c++) run_cycle(0, 1'b0, 8'h08);
    check_eq("beats", 32'(obs_q.size()), 32'd12);
    foreach (obs_q[k]) check_eq("beat_data", 32'(obs_q[k]), 32'h5A);
    check_eq("grants", 32'(gq.size()), 32'd3);
    foreach (gq[k]) check_eq("grant", 32'(gq[k]), 32'h08);

    phase = "fair";
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(one << i);
    run_cycle(0, 1'b1, 8'h00);
    clear_obs();
    for (int c = 0; c < 41; c++) run_cycle(0, 1'b0, 8'hFF);
    check_eq("beats", 32'(obs_q.size()), 32'd32);
    foreach (obs_q[k]) check_eq("seq", 32'(obs_q[k]), 32'(8'(one << (k / 4))));
    check_eq("grants", 32'(gq.size()), 32'd9);
    foreach (gq[k]) check_eq("order", 32'(gq[k]), 32'(8'(one << (k % 8))));
    check_eq("wrap_gnt", 32'(gnt4), 32'h01);

    phase = "early";
    run_cycle(0, 1'b1, 8'h00);
    clear_obs();
    for (int c = 0; c < 3; c++) run_cycle(0, 1'b0, 8'h81);
    run_cycle(0, 1'b0, 8'h80);
    check_eq("released", 32'(gnt4), 32'h0);
    run_cycle(0, 1'b0, 8'h80);
    check_eq("regrant", 32'(gnt4), 32'h80);
    check_eq("beats", 32'(obs_q.size()), 32'd2);

    phase = "midrst";
    run_cycle(0, 1'b1, 8'h00);
    run_cycle(0, 1'b0, 8'h20);
    run_cycle(0, 1'b0, 8'h20);
    run_cycle(0, 1'b1, 8'h20);
    check_eq("dropped_beat", 32'(ov4), 32'h0);
    check_eq("busy_cleared", 32'(busy4), 32'h0);
    clear_obs();
    for (int c = 0; c < 5; c++) run_cycle(0, 1'b0, 8'h20);
    check_eq("beats", 32'(obs_q.size()), 32'd4);
    foreach (obs_q[k]) check_eq("beat_data", 32'(obs_q[k]), 32'h20);
    check_eq("grants", 32'(gq.size()), 32'd1);
    if (gq.size() > 0) check_eq("grant", 32'(gq[0]), 32'h20);

    phase = "mb1";
    run_cycle(1, 1'b1, 8'h00);
    clear_obs();
    for (int c = 0; c < 8; c++) run_cycle(1, 1'b0, 8'h06);
    check_eq("grants", 32'(gq.size()), 32'd4);
    foreach (gq[k]) check_eq("alt", 32'(gq[k]), (k % 2 == 0) ? 32'h02 : 32'h04);
    check_eq("beats", 32'(obs_q.size()), 32'd4);
    foreach (obs_q[k]) check_eq("beat_data", 32'(obs_q[k]), (k % 2 == 0) ? 32'h02 : 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
